// File: rtl/amp_trig_rx.sv
// Amplifier trigger return-path receiver.
// Synchronises the asynchronous acknowledge line and measures trigger-to-acknowledge
// latency and acknowledge pulse width. Also flags timeouts, overruns and spurious
// acknowledges.
module amp_trig_rx #(
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             trig_sent,
  input  logic             amp_ack,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] latency,
  output logic [CNT_W-1:0] width,
  output logic             meas_valid,
  output logic             timeout,
  output logic             overrun,
  output logic             spurious,
  output logic             busy,
  output logic [15:0]      meas_count
);

  typedef enum logic [1:0] {StIdle, StWait, StHigh} state_e;

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_d_q, ack_d_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       lat_hold_q, lat_hold_d;
  logic [CNT_W-1:0]       latency_q, latency_d;
  logic [CNT_W-1:0]       width_q, width_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;
  logic                   spurious_q, spurious_d;
  logic [15:0]            meas_count_q, meas_count_d;

  logic             ack_s;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] wcnt_inc;

  // Synchroniser shift, edge detection and saturating increments.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], amp_ack};
    ack_s    = sync_q[SYNC_STAGES-1];
    ack_d_d  = ack_s;
    rise     = ack_s & ~ack_d_q;
    fall     = ~ack_s & ack_d_q;
    // Fall is registered once more so the result lands SYNC_STAGES+1 edges after
    // the sampled falling edge, together with the drop of busy.
    fall_d   = fall;
    cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    wcnt_inc = (wcnt_q == CntMax) ? wcnt_q : wcnt_q + CntOne;
  end

  // Next-state logic for the measurement FSM and its result registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wcnt_d       = wcnt_q;
    lat_hold_d   = lat_hold_q;
    latency_d    = latency_q;
    width_d      = width_q;
    meas_valid_d = 1'b0;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q & ~clr_flags;
    spurious_d   = spurious_q & ~clr_flags;
    meas_count_d = meas_count_q;

    unique case (state_q)
      StIdle: begin
        if (rise) spurious_d = 1'b1;
        if (trig_sent && enable) begin
          state_d   = StWait;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      StWait: begin
        if (trig_sent) overrun_d = 1'b1;
        if (!enable) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          // A rise on the timeout edge still counts as an acknowledge.
          if (rise) begin
            state_d    = StHigh;
            lat_hold_d = cnt_inc;
            wcnt_d     = CntOne;
          end else if (cnt_inc == TimeoutVal) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end
        end
      end
      StHigh: begin
        if (trig_sent) overrun_d = 1'b1;
        if (!enable) begin
          state_d = StIdle;
        end else begin
          if (ack_s) wcnt_d = wcnt_inc;
          if (fall_q) begin
            state_d      = StIdle;
            latency_d    = lat_hold_q;
            width_d      = wcnt_q;
            meas_valid_d = 1'b1;
            meas_count_d = meas_count_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sync_q       <= '0;
      ack_d_q      <= 1'b0;
      fall_q       <= 1'b0;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      lat_hold_q   <= '0;
      latency_q    <= '0;
      width_q      <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      spurious_q   <= 1'b0;
      meas_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      ack_d_q      <= ack_d_d;
      fall_q       <= fall_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      lat_hold_q   <= lat_hold_d;
      latency_q    <= latency_d;
      width_q      <= width_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      spurious_q   <= spurious_d;
      meas_count_q <= meas_count_d;
    end
  end

  // Output drive.
  always_comb begin
    latency    = latency_q;
    width      = width_q;
    meas_valid = meas_valid_q;
    timeout    = timeout_q;
    overrun    = overrun_q;
    spurious   = spurious_q;
    busy       = (state_q != StIdle);
    meas_count = meas_count_q;
  end

endmodule
